cpu_datapath: RTL and testbench

//  Datapath driven by the CPU controller FSM. Holds PC, IR, ACC, a small register file, the ALU and the z/c flags.

---
 rtl/cpu_datapath.sv | 180 ++++++++++++++++++
 tb/tb_cpu_datapath.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// cpu_datapath: PC, IR, ACC, register file, ALU and z/c flags for the
// accumulator CPU. The controller FSM drives the load/select strobes and
// observes op, z and c.
// Build option: define DP_MOVE_FLAGS_EN so that move/immediate loads into
// ACC (SelAcc = 10/11) also set z from the new ACC and clear c.
module cpu_datapath #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          CLB,
  input  logic [7:0]    imem_data,
  input  logic          LoadIR,
  input  logic          IncPC,
  input  logic          SelPC,
  input  logic          LoadPC,
  input  logic          LoadReg,
  input  logic          LoadAcc,
  input  logic [1:0]    SelAcc,
  input  logic [3:0]    SelALU,
  output logic [AW-1:0] imem_addr,
  output logic [3:0]    op,
  output logic          z,
  output logic          c,
  output logic [DW-1:0] acc_out
);

  localparam int RI = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;

  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    ir_q, ir_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          z_q, z_d;
  logic          c_q, c_d;
  logic [DW-1:0] rf_q [NREG];

  logic [RI-1:0] rs;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] imm_dw;
  logic [AW-1:0] imm_aw;
  logic [AW-1:0] rs_pc;
  logic [DW:0]   add_full;
  logic [DW:0]   sub_full;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_valid;
  logic          jump_taken;

  assign rs       = ir_q[RI-1:0];
  assign rs_val   = rf_q[rs];
  assign add_full = {1'b0, acc_q} + {1'b0, rs_val};
  // Top bit of the extended difference is the borrow (ACC < R).
  assign sub_full = {1'b0, acc_q} - {1'b0, rs_val};

  // Zero-extend the 4-bit immediate and R[rs] to the widths that consume them
  always_comb begin
    imm_dw = '0;
    imm_aw = '0;
    rs_pc  = '0;
    for (int i = 0; i < 4 && i < DW; i++) imm_dw[i] = ir_q[i];
    for (int i = 0; i < 4 && i < AW; i++) imm_aw[i] = ir_q[i];
    for (int i = 0; i < AW && i < DW; i++) rs_pc[i] = rs_val[i];
  end

  // ALU: result, carry/borrow and whether the code is a flag-setting ALU op
  always_comb begin
    alu_res   = acc_q;
    alu_c     = 1'b0;
    alu_valid = 1'b1;
    case (SelALU)
      OP_ADD: begin
        alu_res = add_full[DW-1:0];
        alu_c   = add_full[DW];
      end
      OP_SUB: begin
        alu_res = sub_full[DW-1:0];
        alu_c   = sub_full[DW];
      end
      OP_NOR: alu_res = ~(acc_q | rs_val);
      OP_SHL: begin
        alu_res = acc_q << 1;
        alu_c   = acc_q[DW-1];
      end
      OP_SHR: begin
        alu_res = acc_q >> 1;
        alu_c   = acc_q[0];
      end
      default: alu_valid = 1'b0;
    endcase
  end

  // Jump decision: zero-conditional and carry-conditional jump opcodes
  always_comb begin
    jump_taken = 1'b0;
    if (LoadPC) begin
      case (ir_q[7:4])
        4'b0110, 4'b0111: jump_taken = z_q;
        4'b1000, 4'b1010: jump_taken = c_q;
        default:          jump_taken = 1'b0;
      endcase
    end
  end

  // Next-state for PC, IR, ACC and flags; a taken jump overrides IncPC
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    acc_d = acc_q;
    z_d   = z_q;
    c_d   = c_q;

    if (jump_taken) begin
      pc_d = SelPC ? rs_pc : imm_aw;
    end else if (IncPC) begin
      pc_d = pc_q + AW'(1);
    end

    if (LoadIR) ir_d = imem_data;

    if (LoadAcc) begin
      case (SelAcc)
        2'b00:   acc_d = alu_res;
        2'b10:   acc_d = rs_val;
        2'b11:   acc_d = imm_dw;
        default: acc_d = acc_q;
      endcase
    end

    if (LoadAcc && (SelAcc == 2'b00) && alu_valid) begin
      z_d = (alu_res == '0);
      c_d = alu_c;
    end
`ifdef DP_MOVE_FLAGS_EN
    else if (LoadAcc && SelAcc[1]) begin
      z_d = (acc_d == '0);
      c_d = 1'b0;
    end
`endif
  end

  // State registers; CLB clears everything asynchronously
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      pc_q  <= '0;
      ir_q  <= '0;
      acc_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      acc_q <= acc_d;
      z_q   <= z_d;
      c_q   <= c_d;
    end
  end

  // Register file write: R[rs] takes the pre-edge ACC
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (LoadReg) begin
      rf_q[rs] <= acc_q;
    end
  end

  assign imem_addr = pc_q;
  assign op        = ir_q[7:4];
  assign z         = z_q;
  assign c         = c_q;
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath (DW=AW=8, NREG=4). A reference model
// predicts the post-edge state for every driven cycle; predictions are queued
// and popped once the DUT has clocked. Directed checks pin the key results.
module tb_cpu_datapath;

  logic       clk = 1'b0;
  logic       CLB;
  logic [7:0] imem_data;
  logic       LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;
  logic [7:0] imem_addr;
  logic [3:0] op;
  logic       z, c;
  logic [7:0] acc_out;

  cpu_datapath #(.DW(8), .AW(8), .NREG(4)) dut (
    .clk(clk), .CLB(CLB), .imem_data(imem_data),
    .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU),
    .imem_addr(imem_addr), .op(op), .z(z), .c(c), .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic [3:0] op;
    logic [7:0] acc;
    logic       z;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_pc, m_ir, m_acc;
  logic       m_z, m_c;
  logic [7:0] m_r [4];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    check_eq("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({e.tag, ".pc"},  imem_addr, e.pc);
      check_eq({e.tag, ".op"},  op,        e.op);
      check_eq({e.tag, ".acc"}, acc_out,   e.acc);
      check_eq({e.tag, ".z"},   z,         e.z);
      check_eq({e.tag, ".c"},   c,         e.c);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'h00; m_acc = 8'h00; m_z = 1'b0; m_c = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
  endtask

  task automatic push_model(input string tag);
    exp_t e;
    e.tag = tag; e.pc = m_pc; e.op = m_ir[7:4]; e.acc = m_acc; e.z = m_z; e.c = m_c;
    exp_q.push_back(e);
  endtask

  task automatic clear_strobes();
    LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0; LoadReg = 0; LoadAcc = 0;
    SelAcc = 2'b01; SelALU = 4'h0; imem_data = 8'h00;
  endtask

  // One clocked cycle: drive, predict, clock, compare. Entered just after a negedge.
  task automatic step(input string tag, input logic l_ir, input logic [7:0] d,
                      input logic inc, input logic spc, input logic lpc,
                      input logic lreg, input logic lacc,
                      input logic [1:0] sacc, input logic [3:0] salu);
    logic [3:0] mop;
    logic [1:0] mrs;
    logic [7:0] rv, imm, res, nacc;
    logic [8:0] w;
    logic       rc, valid, nz, nc, take;
    LoadIR = l_ir; imem_data = d; IncPC = inc; SelPC = spc; LoadPC = lpc;
    LoadReg = lreg; LoadAcc = lacc; SelAcc = sacc; SelALU = salu;

    mop = m_ir[7:4]; mrs = m_ir[1:0]; rv = m_r[mrs]; imm = {4'h0, m_ir[3:0]};
    valid = 1'b1; rc = 1'b0; res = m_acc;
    case (salu)
      4'h1: begin w = {1'b0, m_acc} + {1'b0, rv}; res = w[7:0]; rc = w[8]; end
      4'h2: begin res = m_acc - rv; rc = (m_acc < rv); end
      4'h3: res = ~(m_acc | rv);
      4'hB: begin res = {m_acc[6:0], 1'b0}; rc = m_acc[7]; end
      4'hC: begin res = {1'b0, m_acc[7:1]}; rc = m_acc[0]; end
      default: valid = 1'b0;
    endcase
    nacc = m_acc; nz = m_z; nc = m_c;
    if (lacc) begin
      if (sacc == 2'b00) nacc = res;
      else if (sacc == 2'b10) nacc = rv;
      else if (sacc == 2'b11) nacc = imm;
    end
    if (lacc && sacc == 2'b00 && valid) begin nz = (res == 8'h00); nc = rc; end
`ifdef DP_MOVE_FLAGS_EN
    if (lacc && sacc[1]) begin nz = (nacc == 8'h00); nc = 1'b0; end
`endif
    take = lpc && (((mop == 4'h6 || mop == 4'h7) && m_z) ||
                   ((mop == 4'h8 || mop == 4'hA) && m_c));
    if (take) m_pc = spc ? rv : imm;
    else if (inc) m_pc = m_pc + 8'h01;
    if (lreg) m_r[mrs] = m_acc;
    if (l_ir) m_ir = d;
    m_acc = nacc; m_z = nz; m_c = nc;
    push_model(tag);

    @(posedge clk);
    #1;
    compare_out();
    @(negedge clk);
    clear_strobes();
  endtask

  task automatic set_ir(input logic [7:0] d);
    step("ldir", 1, d, 0, 0, 0, 0, 0, 2'b01, 4'h0);
  endtask

  task automatic ldim(input logic [3:0] v);
    set_ir({4'hD, v});
    step("ldim", 0, 8'h00, 0, 0, 0, 0, 1, 2'b11, 4'h0);
  endtask

  task automatic alu(input logic [3:0] code, input logic [1:0] rs);
    set_ir({code, 2'b00, rs});
    step("alu", 0, 8'h00, 0, 0, 0, 0, 1, 2'b00, code);
  endtask

  task automatic store(input logic [1:0] rs);
    set_ir({4'h9, 2'b00, rs});
    step("st", 0, 8'h00, 0, 0, 0, 1, 0, 2'b01, 4'h0);
  endtask

  task automatic mov(input logic [1:0] rs);
    set_ir({4'hE, 2'b00, rs});
    step("mov", 0, 8'h00, 0, 0, 0, 0, 1, 2'b10, 4'h0);
  endtask

  // ACC = v, built from two nibbles through scratch register R3
  task automatic set_acc(input logic [7:0] v);
    ldim(v[7:4]);
    for (int i = 0; i < 4; i++) alu(4'hB, 2'd0);
    store(2'd3);
    ldim(v[3:0]);
    alu(4'h1, 2'd3);
  endtask

  task automatic set_reg(input logic [1:0] rs, input logic [7:0] v);
    set_acc(v);
    store(rs);
  endtask

  task automatic jump(input string tag, input logic inc, input logic spc);
    step(tag, 0, 8'h00, inc, spc, 1, 0, 0, 2'b01, 4'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    CLB = 1'b0;
    clear_strobes();
    model_reset();
    repeat (2) @(negedge clk);
    push_model("por");
    compare_out();
    CLB = 1'b1;

    // ADD overflow to zero
    set_reg(2'd1, 8'hFB);
    ldim(4'h5);
    alu(4'h1, 2'd1);
    check_eq("add.acc", acc_out, 8'h00);
    check_eq("add.z", z, 1'b1);
    check_eq("add.c", c, 1'b1);

    // SUB with borrow, NOR to zero
    set_reg(2'd2, 8'h05);
    set_acc(8'h03);
    alu(4'h2, 2'd2);
    check_eq("sub.acc", acc_out, 8'hFE);
    check_eq("sub.z", z, 1'b0);
    check_eq("sub.c", c, 1'b1);
    set_reg(2'd1, 8'h0F);
    set_acc(8'hF0);
    alu(4'h3, 2'd1);
    check_eq("nor.acc", acc_out, 8'h00);
    check_eq("nor.z", z, 1'b1);
    check_eq("nor.c", c, 1'b0);

    // Shifts and a non-ALU code
    set_acc(8'h81);
    alu(4'hB, 2'd0);
    check_eq("shl.acc", acc_out, 8'h02);
    check_eq("shl.c", c, 1'b1);
    alu(4'hC, 2'd0);
    alu(4'hC, 2'd0);
    check_eq("shr.acc", acc_out, 8'h00);
    check_eq("shr.zc", {z, c}, 2'b11);
    alu(4'h5, 2'd0);
    check_eq("other.zc", {z, c}, 2'b11);
    mov(2'd2);
    check_eq("mov.acc", acc_out, 8'h05);

    // Conditional jumps on z (immediate) and c (register)
    set_acc(8'h00);
    set_ir(8'h65);
    jump("jz5", 0, 0);
    check_eq("jz5.pc", imem_addr, 8'h05);
    set_acc(8'h01);
    set_ir(8'h7A);
    jump("jz_nt", 0, 0);
    check_eq("jz_nt.pc", imem_addr, 8'h05);
    set_acc(8'h00);
    set_ir(8'h7A);
    jump("jz_t", 0, 0);
    check_eq("jz_t.pc", imem_addr, 8'h0A);
    set_reg(2'd0, 8'h33);
    set_acc(8'h81);
    alu(4'hB, 2'd0);
    set_ir(8'h80);
    jump("jcrs", 0, 1);
    check_eq("jcrs.pc", imem_addr, 8'h33);

    // PC wrap and LoadPC/IncPC priority
    while (m_pc != 8'hFF) step("inc", 0, 8'h00, 1, 0, 0, 0, 0, 2'b01, 4'h0);
    step("wrap", 0, 8'h00, 1, 0, 0, 0, 0, 2'b01, 4'h0);
    check_eq("wrap.pc", imem_addr, 8'h00);
    set_acc(8'h00);
    set_ir(8'h7A);
    jump("jinc", 1, 0);
    check_eq("jinc.pc", imem_addr, 8'h0A);
    set_ir(8'h8A);
    jump("jc_nt_inc", 1, 0);
    check_eq("jc_nt_inc.pc", imem_addr, 8'h0B);
    set_ir(8'h15);
    jump("nonjmp", 0, 0);
    jump("nonjmp_inc", 1, 0);
    check_eq("nonjmp.pc", imem_addr, 8'h0C);

    // Coincident LoadReg and LoadAcc use pre-edge ACC
    set_acc(8'h42);
    set_ir(8'hD2);
    step("regacc", 0, 8'h00, 0, 0, 0, 1, 1, 2'b11, 4'h0);
    check_eq("regacc.acc", acc_out, 8'h02);
    mov(2'd2);
    check_eq("regacc.r2", acc_out, 8'h42);

    // Immediate load after z=1, c=1
    ldim(4'h8);
    for (int i = 0; i < 5; i++) alu(4'hB, 2'd0);
    check_eq("pre_ldim.zc", {z, c}, 2'b11);
    ldim(4'h3);
`ifdef DP_MOVE_FLAGS_EN
    check_eq("ldim.zc", {z, c}, 2'b00);
`else
    check_eq("ldim.zc", {z, c}, 2'b11);
`endif
    check_eq("ldim.acc", acc_out, 8'h03);

    // Asynchronous reset mid-cycle
    #2;
    CLB = 1'b0;
    model_reset();
    #1;
    push_model("async_rst");
    compare_out();
    @(negedge clk);
    CLB = 1'b1;
    mov(2'd1);
    check_eq("rst.r1", acc_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
